bstep_ste_backward: RTL and testbench
=====================================

Name: bstep_ste_backward

Overview:
Backward-pass partner for the 8-bit binary-step activation in the activation-function library.
- Forward side: captures each forward input, emits its step output, and pushes the input into a context FIFO.
- Backward side: pops the saved inputs in the same order and gates the incoming upstream gradient with a clipped straight-through estimator (STE) mask.
- Sits between the forward activation stage and the gradient path of the training datapath.

Parameters:
- W, 8: data width of activation inputs and gradients; two's complement.
- DEPTH, 16: context FIFO depth; power of 2, minimum 2.
- CLIP, 64: STE pass window; gradient passes when -CLIP <= x <= CLIP. Range 0..2^(W-1)-1.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst_n  in  1  synchronous active-low reset.
- Fwd_Valid  in  1  forward input valid.
- Fwd_In  in  W  forward activation input, signed.
- Fwd_Ready  out  1  forward input accepted when high.
- Fwd_Out  out  1  registered step output.
- Fwd_Out_Valid  out  1  one-cycle pulse qualifying Fwd_Out.
- Grad_In_Valid  in  1  upstream gradient valid.
- Grad_In  in  W  upstream gradient, signed.
- Grad_In_Ready  out  1  gradient accepted when high.
- Grad_Out_Valid  out  1  output gradient valid.
- Grad_Out  out  W  gated gradient.
- Grad_Out_Ready  in  1  downstream ready.
- Ctx_Count  out  log2(DEPTH)+1  saved entries currently held.
- Err_Underflow  out  1  sticky error flag.

Behaviour:
Reset (Rst_n low at a rising edge):
- Clears FIFO pointers and count.
- Clears Fwd_Out, Fwd_Out_Valid, Grad_Out, Grad_Out_Valid, Err_Underflow to 0.
- Reset mid-operation discards all stored context and any pending Grad_Out.

Forward path:
- Fwd_Ready = (Ctx_Count < DEPTH), computed from registered count only.
- Forward accept = Fwd_Valid & Fwd_Ready.
- On accept: Fwd_In is written at the write pointer, and the write pointer increments mod DEPTH.
- The following cycle: Fwd_Out = (Fwd_In >= 0 signed) ? 1 : 0 and Fwd_Out_Valid = 1.
- Fwd_Out_Valid is 0 in any cycle following no accept. Fwd_Out holds its last value.
- No forward backpressure beyond FIFO full.

Backward path:
- Output register is free when (!Grad_Out_Valid | Grad_Out_Ready).
- Grad_In_Ready = (Ctx_Count != 0) & (output register free).
- Backward accept = Grad_In_Valid & Grad_In_Ready.
- On accept: pop x from the read pointer and increment the read pointer mod DEPTH.
  - mask = (x >= -CLIP) & (x <= CLIP), signed compare.
  - Next cycle: Grad_Out = mask ? Grad_In : 0, and Grad_Out_Valid = 1.
- Latency: 1 cycle. Full throughput of one gradient per cycle while Grad_Out_Ready is held high.
- Grad_Out_Valid & !Grad_Out_Ready: Grad_Out and Grad_Out_Valid hold stable.
- Grad_Out_Valid clears after a handshake with no new accept in the same cycle.

Ordering:
- Gradients pair with saved inputs strictly FIFO.
- The upstream gradient order must equal the forward order.

Count:
- Ctx_Count += forward accept, -= backward accept.
- Simultaneous push and pop leaves the count unchanged, and both the data write and read occur.
- Push is refused when full even if a pop occurs in the same cycle.
- Pop is refused when empty even if a push occurs in the same cycle; the new entry is poppable on the next cycle.

Wrap-around:
- Pointers are log2(DEPTH) bits and wrap naturally.
- Full/empty are derived from Ctx_Count only.

Err_Underflow:
- Set when Grad_In_Valid = 1 while Ctx_Count = 0.
- Cleared only by reset.
- Has no effect on datapath state.

Boundaries:
- x = CLIP and x = -CLIP pass the gradient.
- x = CLIP+1 and x = -CLIP-1 block it.
- x = -128 always blocks (for CLIP <= 127).

Test Plan:
- Reset then push Fwd_In = 5, -3, 0 -> Fwd_Out = 1, 0, 1, one cycle after each accept; Ctx_Count = 3.
- With context {64, 65, -64, -65, -128} (CLIP = 64), send gradients 10, 20, 30, 40, 50 -> Grad_Out = 10, 0, 30, 0, 0 in order, 1-cycle latency; Ctx_Count returns to 0.
- Push 16 entries (DEPTH = 16) -> Fwd_Ready = 0 with Fwd_Valid held. Then in one cycle Fwd_Valid = 1 and Grad_In_Valid = 1 -> pop only, count 15. Next cycle a simultaneous push and pop keeps count at 15. Pointers wrap over 40 mixed operations with data order preserved.
- Hold Grad_Out_Ready = 0 for 3 cycles with a pending output of 7 -> Grad_Out stays 7, valid stays high, Grad_In_Ready = 0; on release, back-to-back gradients stream at 1 per cycle.
- Grad_In_Valid = 1 with empty FIFO -> Grad_In_Ready = 0, Err_Underflow = 1 sticky, no Grad_Out_Valid. A subsequent push of 2 plus gradient 9 -> Grad_Out = 9.
- Assert Rst_n = 0 for one cycle with 5 entries stored and Grad_Out_Valid high -> all outputs 0, Ctx_Count = 0, Fwd_Ready = 1, Err_Underflow = 0.

Source files
------------

// File: rtl/bstep_ste_backward.sv
// bstep_ste_backward: binary-step forward output with a clipped-STE gated gradient on the backward pass
module bstep_ste_backward #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int CLIP = 64
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Fwd_Valid,
  input  logic [W-1:0]               Fwd_In,
  output logic                       Fwd_Ready,
  output logic                       Fwd_Out,
  output logic                       Fwd_Out_Valid,
  input  logic                       Grad_In_Valid,
  input  logic [W-1:0]               Grad_In,
  output logic                       Grad_In_Ready,
  output logic                       Grad_Out_Valid,
  output logic [W-1:0]               Grad_Out,
  input  logic                       Grad_Out_Ready,
  output logic [$clog2(DEPTH):0]     Ctx_Count,
  output logic                       Err_Underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [W:0] CLIP_HI = (W+1)'(CLIP);
  localparam logic signed [W:0] CLIP_LO = -(W+1)'(CLIP);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, mask;
  logic signed [W:0] x;
  assign Fwd_Ready = Ctx_Count < (AW+1)'(DEPTH);
  assign Grad_In_Ready = (Ctx_Count != '0) & (!Grad_Out_Valid | Grad_Out_Ready);
  assign push = Fwd_Valid & Fwd_Ready;
  assign pop = Grad_In_Valid & Grad_In_Ready;
  // sign-extend by one bit so -CLIP is representable for any CLIP in range
  assign x = {mem[rd_ptr][W-1], mem[rd_ptr]};
  assign mask = (x >= CLIP_LO) & (x <= CLIP_HI);
  always_ff @(posedge Clk)
    if (push) mem[wr_ptr] <= Fwd_In;
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Ctx_Count <= '0;
      Fwd_Out <= 1'b0;
      Fwd_Out_Valid <= 1'b0;
      Grad_Out <= '0;
      Grad_Out_Valid <= 1'b0;
      Err_Underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      Ctx_Count <= Ctx_Count + (AW+1)'(push) - (AW+1)'(pop);
      Fwd_Out_Valid <= push;
      if (push) Fwd_Out <= !Fwd_In[W-1];
      if (pop) begin
        Grad_Out <= mask ? Grad_In : '0;
        Grad_Out_Valid <= 1'b1;
      end else if (Grad_Out_Ready) Grad_Out_Valid <= 1'b0;
      if (Grad_In_Valid && Ctx_Count == '0) Err_Underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bstep_ste_backward.sv
// tb_bstep_ste_backward: queue-model checked every cycle plus literal expectations for directed scenarios
module tb_bstep_ste_backward;
  logic Clk = 0, Rst_n = 0;
  logic Fwd_Valid = 0, Grad_In_Valid = 0, Grad_Out_Ready = 1;
  logic [7:0] Fwd_In = 0, Grad_In = 0;
  logic Fwd_Ready, Fwd_Out, Fwd_Out_Valid, Grad_In_Ready, Grad_Out_Valid, Err_Underflow;
  logic [7:0] Grad_Out;
  logic [4:0] Ctx_Count;
  int tests = 0, fails = 0;
  int q[$], got_g[$], got_f[$];
  int m_fo = 0, m_fov = 0, m_go = 0, m_gov = 0, m_err = 0;
  bit live = 0;

  bstep_ste_backward dut (
    .Clk(Clk), .Rst_n(Rst_n), .Fwd_Valid(Fwd_Valid), .Fwd_In(Fwd_In), .Fwd_Ready(Fwd_Ready),
    .Fwd_Out(Fwd_Out), .Fwd_Out_Valid(Fwd_Out_Valid), .Grad_In_Valid(Grad_In_Valid),
    .Grad_In(Grad_In), .Grad_In_Ready(Grad_In_Ready), .Grad_Out_Valid(Grad_Out_Valid),
    .Grad_Out(Grad_Out), .Grad_Out_Ready(Grad_Out_Ready), .Ctx_Count(Ctx_Count),
    .Err_Underflow(Err_Underflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(string n, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // model: context is a plain queue, outputs derived directly from the accept rules
  always @(posedge Clk) begin
    if (!Rst_n) begin
      q.delete();
      {m_fo, m_fov, m_go, m_gov, m_err} = '0;
      live = 1;
    end else begin
      bit fr, gr, psh, pp;
      fr = q.size() < 16;
      gr = q.size() != 0 && (!m_gov || Grad_Out_Ready);
      psh = Fwd_Valid && fr;
      pp = Grad_In_Valid && gr;
      if (Grad_In_Valid && q.size() == 0) m_err = 1;
      if (pp) begin
        int x;
        x = q.pop_front();
        m_go = (x >= -64 && x <= 64) ? int'($signed(Grad_In)) : 0;
        m_gov = 1;
      end else if (Grad_Out_Ready) m_gov = 0;
      if (psh) begin
        q.push_back(int'($signed(Fwd_In)));
        m_fo = $signed(Fwd_In) >= 0;
        m_fov = 1;
      end else m_fov = 0;
    end
  end

  always @(negedge Clk) if (live) begin
    chk("ctx_count", Ctx_Count, q.size());
    chk("fwd_ready", Fwd_Ready, q.size() < 16);
    chk("grad_in_ready", Grad_In_Ready, q.size() != 0 && (!m_gov || Grad_Out_Ready));
    chk("fwd_out_valid", Fwd_Out_Valid, m_fov);
    chk("fwd_out", Fwd_Out, m_fo);
    chk("grad_out_valid", Grad_Out_Valid, m_gov);
    if (m_gov) chk("grad_out", $signed(Grad_Out), m_go);
    chk("err_underflow", Err_Underflow, m_err);
    if (Fwd_Out_Valid) got_f.push_back(Fwd_Out);
    if (Grad_Out_Valid && Grad_Out_Ready) got_g.push_back($signed(Grad_Out));
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push(int v);
    Fwd_Valid = 1; Fwd_In = 8'(v); step(); Fwd_Valid = 0;
  endtask

  task automatic grad(int v);
    Grad_In_Valid = 1; Grad_In = 8'(v); step(); Grad_In_Valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    Grad_Out_Ready = 1;
    while (Ctx_Count != 0 && n < 64) begin
      grad(n);
      n++;
    end
    step();
    chk("drain_empty", Ctx_Count, 0);
  endtask

  initial begin
    int ctx[5] = '{64, 65, -64, -65, -128};
    step(2);
    chk("rst_count", Ctx_Count, 0);
    chk("rst_fwd_ready", Fwd_Ready, 1);
    Rst_n = 1;
    step();
    push(5); push(-3); push(0); step();
    chk("fwd_n", got_f.size(), 3);
    if (got_f.size() == 3) begin
      chk("fwd_5", got_f[0], 1); chk("fwd_m3", got_f[1], 0); chk("fwd_0", got_f[2], 1);
    end
    chk("count3", Ctx_Count, 3);
    drain();
    got_g.delete();
    foreach (ctx[i]) push(ctx[i]);
    for (int i = 1; i <= 5; i++) grad(i * 10);
    step();
    chk("ste_n", got_g.size(), 5);
    if (got_g.size() == 5) begin
      chk("ste_64", got_g[0], 10); chk("ste_65", got_g[1], 0); chk("ste_m64", got_g[2], 30);
      chk("ste_m65", got_g[3], 0); chk("ste_m128", got_g[4], 0);
    end
    chk("ste_count0", Ctx_Count, 0);
    Fwd_Valid = 1;
    for (int i = 0; i < 16; i++) begin Fwd_In = 8'(i * 9 - 70); step(); end
    chk("full_ready", Fwd_Ready, 0);
    step();
    chk("full_count", Ctx_Count, 16);
    Grad_In_Valid = 1; Grad_In = 8'd3; step();
    chk("full_pop_only", Ctx_Count, 15);
    step();
    chk("push_pop_same", Ctx_Count, 15);
    for (int i = 0; i < 40; i++) begin
      Fwd_Valid = 1'($urandom); Fwd_In = 8'($urandom);
      Grad_In_Valid = 1'($urandom); Grad_In = 8'($urandom);
      step();
    end
    Fwd_Valid = 0; Grad_In_Valid = 0;
    drain();
    got_g.delete();
    push(1); push(2); push(3); push(4);
    Grad_Out_Ready = 0;
    grad(7);
    Grad_In_Valid = 1; Grad_In = 8'd8;
    for (int i = 0; i < 3; i++) begin
      chk("hold_val", $signed(Grad_Out), 7);
      chk("hold_valid", Grad_Out_Valid, 1);
      chk("hold_ready", Grad_In_Ready, 0);
      step();
    end
    Grad_Out_Ready = 1;
    step(); Grad_In = 8'd9; step(); Grad_In = 8'd10; step(); Grad_In_Valid = 0; step();
    chk("stream_n", got_g.size(), 4);
    if (got_g.size() == 4) begin
      chk("stream0", got_g[0], 7); chk("stream1", got_g[1], 8);
      chk("stream2", got_g[2], 9); chk("stream3", got_g[3], 10);
    end
    chk("under_ready", Grad_In_Ready, 0);
    grad(5);
    chk("under_err", Err_Underflow, 1);
    chk("under_novalid", Grad_Out_Valid, 0);
    step();
    chk("under_sticky", Err_Underflow, 1);
    got_g.delete();
    push(2); grad(9); step();
    chk("after_under", got_g.size() == 1 ? got_g[0] : -999, 9);
    for (int i = 0; i < 6; i++) push(i + 20);
    Grad_Out_Ready = 0;
    grad(11);
    chk("pre_rst_count", Ctx_Count, 5);
    chk("pre_rst_valid", Grad_Out_Valid, 1);
    Rst_n = 0; step();
    chk("mrst_count", Ctx_Count, 0);
    chk("mrst_ready", Fwd_Ready, 1);
    chk("mrst_err", Err_Underflow, 0);
    chk("mrst_gvalid", Grad_Out_Valid, 0);
    chk("mrst_gout", Grad_Out, 0);
    chk("mrst_fout", Fwd_Out, 0);
    chk("mrst_fvalid", Fwd_Out_Valid, 0);
    Rst_n = 1; Grad_Out_Ready = 1; step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
